// File: rtl/prod_table_mp.sv
// Register producer table: per-register pending bit and ROB tag, with multi-slot
// issue claims, ROB commit clearing, intra-group forwarding and a commit bypass.
module prod_table_mp #(
   parameter int NUM_REGS   = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TAG_W      = 4,
   parameter int ISSUE_W    = 2,
   parameter int COMMIT_W   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall_i,
   input  logic                             flush_i,
   input  logic [ISSUE_W-1:0]               issue_en,
   input  logic [ISSUE_W*REG_ADDR_W-1:0]    rd_addr,
   input  logic [ISSUE_W*TAG_W-1:0]         rd_tag,
   input  logic [ISSUE_W*REG_ADDR_W-1:0]    r1_addr,
   input  logic [ISSUE_W*REG_ADDR_W-1:0]    r2_addr,
   output logic [ISSUE_W-1:0]               r1_valid,
   output logic [ISSUE_W-1:0]               r2_valid,
   output logic [ISSUE_W*TAG_W-1:0]         r1_tag,
   output logic [ISSUE_W*TAG_W-1:0]         r2_tag,
   input  logic [COMMIT_W-1:0]              rob_en,
   input  logic [COMMIT_W*REG_ADDR_W-1:0]   rob_dest,
   input  logic [COMMIT_W*TAG_W-1:0]        rob_tag,
   output logic [$clog2(NUM_REGS+1)-1:0]    pend_cnt
);
   localparam int CNT_W = $clog2(NUM_REGS + 1);

   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [TAG_W-1:0]    tag_q   [NUM_REGS];
   logic [TAG_W-1:0]    tag_nxt [NUM_REGS];
   logic [CNT_W-1:0]    cnt_inc;
   logic [CNT_W-1:0]    cnt_dec;
   logic [CNT_W-1:0]    cnt_nxt;

   // Priority, lowest to highest: table, commit bypass, older-slot forward, reg 0.
   function automatic logic [TAG_W:0] lookup(input logic [REG_ADDR_W-1:0] a, input int slot);
      logic             v;
      logic [TAG_W-1:0] t;
      v = pend_q[a];
      t = tag_q[a];
      for (int c = 0; c < COMMIT_W; c++) begin
         if (rob_en[c] && rob_dest[c*REG_ADDR_W +: REG_ADDR_W] == a && pend_q[a] &&
             rob_tag[c*TAG_W +: TAG_W] == tag_q[a])
            v = 1'b0;
      end
      for (int j = 0; j < ISSUE_W; j++) begin
         if (j < slot && issue_en[j] && rd_addr[j*REG_ADDR_W +: REG_ADDR_W] == a) begin
            v = 1'b1;
            t = rd_tag[j*TAG_W +: TAG_W];
         end
      end
      if (a == '0)
         v = 1'b0;
      if (!v)
         t = '0;
      return {v, t};
   endfunction

   always_comb begin
      r1_valid = '0;
      r2_valid = '0;
      r1_tag   = '0;
      r2_tag   = '0;
      for (int s = 0; s < ISSUE_W; s++) begin
         {r1_valid[s], r1_tag[s*TAG_W +: TAG_W]} = lookup(r1_addr[s*REG_ADDR_W +: REG_ADDR_W], s);
         {r2_valid[s], r2_tag[s*TAG_W +: TAG_W]} = lookup(r2_addr[s*REG_ADDR_W +: REG_ADDR_W], s);
      end
   end

   // Commits evaluate against current state; later issue writes override them.
   always_comb begin
      pend_nxt = pend_q;
      tag_nxt  = tag_q;
      for (int c = 0; c < COMMIT_W; c++) begin
         if (rob_en[c] && pend_q[rob_dest[c*REG_ADDR_W +: REG_ADDR_W]] &&
             tag_q[rob_dest[c*REG_ADDR_W +: REG_ADDR_W]] == rob_tag[c*TAG_W +: TAG_W])
            pend_nxt[rob_dest[c*REG_ADDR_W +: REG_ADDR_W]] = 1'b0;
      end
      if (!stall_i) begin
         for (int s = 0; s < ISSUE_W; s++) begin
            if (issue_en[s] && rd_addr[s*REG_ADDR_W +: REG_ADDR_W] != '0) begin
               pend_nxt[rd_addr[s*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
               tag_nxt[rd_addr[s*REG_ADDR_W +: REG_ADDR_W]]  = rd_tag[s*TAG_W +: TAG_W];
            end
         end
      end
      if (flush_i) begin
         pend_nxt = '0;
         for (int r = 0; r < NUM_REGS; r++)
            tag_nxt[r] = '0;
      end
      pend_nxt[0] = 1'b0;
   end

   always_comb begin
      cnt_inc = '0;
      cnt_dec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (pend_nxt[r] && !pend_q[r])
            cnt_inc = cnt_inc + CNT_W'(1);
         if (!pend_nxt[r] && pend_q[r])
            cnt_dec = cnt_dec + CNT_W'(1);
      end
      cnt_nxt = pend_cnt + cnt_inc - cnt_dec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q   <= '0;
         pend_cnt <= '0;
         for (int r = 0; r < NUM_REGS; r++)
            tag_q[r] <= '0;
      end else begin
         pend_q   <= pend_nxt;
         pend_cnt <= cnt_nxt;
         for (int r = 0; r < NUM_REGS; r++)
            tag_q[r] <= tag_nxt[r];
      end
   end
endmodule

// File: tb/tb_prod_table_mp.sv
// Directed bench for prod_table_mp: hand-computed expectations checked by
// immediate assertions at each step.
module tb_prod_table_mp;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i;
   logic [1:0]  issue_en;
   logic [9:0]  rd_addr, r1_addr, r2_addr;
   logic [7:0]  rd_tag, r1_tag, r2_tag;
   logic [1:0]  r1_valid, r2_valid;
   logic [1:0]  rob_en;
   logic [9:0]  rob_dest;
   logic [7:0]  rob_tag;
   logic [5:0]  pend_cnt;

   int checks   = 0;
   int failures = 0;

   prod_table_mp dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .issue_en(issue_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
      .r1_addr(r1_addr), .r2_addr(r2_addr),
      .r1_valid(r1_valid), .r2_valid(r2_valid), .r1_tag(r1_tag), .r2_tag(r2_tag),
      .rob_en(rob_en), .rob_dest(rob_dest), .rob_tag(rob_tag), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic idle();
      stall_i = 0; flush_i = 0; issue_en = '0; rd_addr = '0; rd_tag = '0;
      r1_addr = '0; r2_addr = '0; rob_en = '0; rob_dest = '0; rob_tag = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      rst = 0;
      idle();
      #12;
      chk("rst_cnt", 32'(pend_cnt), 0);
      @(negedge clk);
      rst = 1;
      r1_addr[4:0] = 10;
      #1;
      chk("init_v", 32'(r1_valid[0]), 0);
      chk("init_t", 32'(r1_tag[3:0]), 0);
      chk("init_cnt", 32'(pend_cnt), 0);

      // claim then commit
      tick();
      issue_en = 2'b01; rd_addr[4:0] = 10; rd_tag[3:0] = 7;
      tick();
      r1_addr[4:0] = 10; #1;
      chk("claim_v", 32'(r1_valid[0]), 1);
      chk("claim_t", 32'(r1_tag[3:0]), 7);
      chk("claim_cnt", 32'(pend_cnt), 1);
      rob_en = 2'b01; rob_dest[4:0] = 10; rob_tag[3:0] = 7; #1;
      chk("bypass_v", 32'(r1_valid[0]), 0);
      chk("bypass_t", 32'(r1_tag[3:0]), 0);
      tick();
      r1_addr[4:0] = 10; #1;
      chk("commit_cnt", 32'(pend_cnt), 0);
      chk("commit_v", 32'(r1_valid[0]), 0);

      // intra-group forwarding and same-register claim ordering
      issue_en = 2'b01; rd_addr[4:0] = 5; rd_tag[3:0] = 3;
      r2_addr[9:5] = 5; r2_addr[4:0] = 5; #1;
      chk("fwd_v", 32'(r2_valid[1]), 1);
      chk("fwd_t", 32'(r2_tag[7:4]), 3);
      chk("nofwd_s0", 32'(r2_valid[0]), 0);
      tick();
      issue_en = 2'b11; rd_addr = {5'd6, 5'd6}; rd_tag = {4'd2, 4'd1};
      tick();
      r1_addr[4:0] = 6; r2_addr[4:0] = 5; #1;
      chk("dup_t", 32'(r1_tag[3:0]), 2);
      chk("dup_v", 32'(r1_valid[0]), 1);
      chk("r5_t", 32'(r2_tag[3:0]), 3);
      chk("dup_cnt", 32'(pend_cnt), 2);

      // forwarding still applies under stall, but nothing is written
      stall_i = 1; issue_en = 2'b01; rd_addr[4:0] = 7; rd_tag[3:0] = 5; r1_addr[9:5] = 7; #1;
      chk("stallfwd_v", 32'(r1_valid[1]), 1);
      chk("stallfwd_t", 32'(r1_tag[7:4]), 5);
      tick();
      r1_addr[4:0] = 7; #1;
      chk("stall7_v", 32'(r1_valid[0]), 0);
      chk("stall7_cnt", 32'(pend_cnt), 2);

      // stale commit, issue-over-commit, duplicate commit
      issue_en = 2'b01; rd_addr[4:0] = 10; rd_tag[3:0] = 7;
      tick();
      rob_en = 2'b01; rob_dest[4:0] = 10; rob_tag[3:0] = 4; r1_addr[4:0] = 10; #1;
      chk("stale_byp_v", 32'(r1_valid[0]), 1);
      chk("stale_byp_t", 32'(r1_tag[3:0]), 7);
      tick();
      r1_addr[4:0] = 10; #1;
      chk("stale_v", 32'(r1_valid[0]), 1);
      chk("stale_t", 32'(r1_tag[3:0]), 7);
      chk("stale_cnt", 32'(pend_cnt), 3);
      issue_en = 2'b01; rd_addr[4:0] = 10; rd_tag[3:0] = 9;
      rob_en = 2'b10; rob_dest[9:5] = 10; rob_tag[7:4] = 7;
      tick();
      r1_addr[4:0] = 10; #1;
      chk("iss_over_cmt_v", 32'(r1_valid[0]), 1);
      chk("iss_over_cmt_t", 32'(r1_tag[3:0]), 9);
      chk("iss_over_cmt_cnt", 32'(pend_cnt), 3);
      rob_en = 2'b11; rob_dest = {5'd10, 5'd10}; rob_tag = {4'd9, 4'd9};
      tick();
      r1_addr[4:0] = 10; #1;
      chk("dupcmt_v", 32'(r1_valid[0]), 0);
      chk("dupcmt_cnt", 32'(pend_cnt), 2);

      // stalled issue is dropped
      stall_i = 1; issue_en = 2'b01; rd_addr[4:0] = 12; rd_tag[3:0] = 2;
      tick();
      r1_addr[4:0] = 12; #1;
      chk("stall12_v", 32'(r1_valid[0]), 0);
      chk("stall12_cnt", 32'(pend_cnt), 2);

      // fill to 8 pending (5,6 + 1,2,3,4,8,9), then flush with a concurrent issue
      issue_en = 2'b11; rd_addr = {5'd2, 5'd1}; rd_tag = {4'd2, 4'd1};
      tick();
      issue_en = 2'b11; rd_addr = {5'd4, 5'd3}; rd_tag = {4'd4, 4'd3};
      tick();
      issue_en = 2'b11; rd_addr = {5'd9, 5'd8}; rd_tag = {4'd9, 4'd8};
      tick();
      #1;
      chk("fill_cnt", 32'(pend_cnt), 8);
      flush_i = 1; issue_en = 2'b11; rd_addr = {5'd13, 5'd11}; rd_tag = {4'd5, 4'd6};
      r1_addr[4:0] = 5; #1;
      chk("flushcyc_v", 32'(r1_valid[0]), 1);
      chk("flushcyc_t", 32'(r1_tag[3:0]), 3);
      tick();
      r1_addr = {5'd6, 5'd5}; r2_addr = {5'd13, 5'd11}; #1;
      chk("flush_cnt", 32'(pend_cnt), 0);
      chk("flush_r1v", 32'(r1_valid), 0);
      chk("flush_r2v", 32'(r2_valid), 0);
      chk("flush_tags", 32'({r1_tag, r2_tag}), 0);

      // register 0 is never claimed
      issue_en = 2'b11; rd_addr = {5'd20, 5'd0}; rd_tag = {4'd6, 4'd5};
      tick();
      r1_addr[4:0] = 0; #1;
      chk("r0_v", 32'(r1_valid[0]), 0);
      chk("r0_t", 32'(r1_tag[3:0]), 0);
      chk("r0_cnt", 32'(pend_cnt), 1);
      issue_en = 2'b11; rd_addr = {5'd22, 5'd21}; rd_tag = {4'd8, 4'd7};
      tick();
      r1_addr[4:0] = 20; r2_addr[4:0] = 22; #1;
      chk("pre_rst_cnt", 32'(pend_cnt), 3);
      chk("pre_rst_v", 32'(r1_valid[0]), 1);

      // asynchronous reset mid-cycle
      #1;
      rst = 0;
      #1;
      chk("arst_cnt", 32'(pend_cnt), 0);
      chk("arst_v", 32'({r1_valid[0], r2_valid[0]}), 0);
      chk("arst_t", 32'({r1_tag[3:0], r2_tag[3:0]}), 0);
      @(negedge clk);
      rst = 1;
      issue_en = 2'b01; rd_addr[4:0] = 23; rd_tag[3:0] = 1;
      tick();
      r1_addr[4:0] = 23; r2_addr[4:0] = 20; #1;
      chk("post_rst_cnt", 32'(pend_cnt), 1);
      chk("post_rst_t", 32'(r1_tag[3:0]), 1);
      chk("post_rst_old", 32'(r2_valid[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
